register_writeback_buffer: RTL

REGISTER_WRITEBACK_BUFFER -- requirements
Module: register_writeback_buffer

---
 rtl/register_writeback_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/register_writeback_buffer.sv
// register_writeback_buffer
//
// In-order FIFO of {address, data} writeback requests that drains into a
// register file write port which always accepts. While entries are pending,
// the head is presented on write/address/data_in and pops on every edge.
// Writes to register 31 (XZR) are accepted but dropped. Two read selects are
// compared against all pending entries to flag read-after-write hazards.
//
// Optional feature: define WB_BYPASS_EN to add bypass_data_a/bypass_data_b,
// which carry the data of the youngest pending write to the selected register.
//
// Ports:
//   clock               rising-edge clock
//   reset               asynchronous, active-low; clears all valid state
//   in_valid/in_ready   producer handshake (see below)
//   in_address, in_data writeback request payload
//   write               register file write strobe (head entry valid)
//   address, data_in    register file write address/data (0 when idle)
//   select_a, select_b  register file read selects to check
//   hazard_a, hazard_b  a pending write targets the selected register
//   bypass_data_a/_b    (WB_BYPASS_EN only) youngest matching pending data
//   count               number of pending entries
//
// Handshake: a request transfers on a rising edge where in_valid=1 and
// in_ready=1. in_ready depends only on registered occupancy (count<DEPTH), so
// it never combinationally depends on in_valid or on the same-cycle pop. A
// producer seeing in_ready=0 holds its request stable until it is accepted.
module register_writeback_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_address,
  input  logic [63:0]             in_data,
  output logic                    write,
  output logic [4:0]              address,
  output logic [63:0]             data_in,
  input  logic [4:0]              select_a,
  input  logic [4:0]              select_b,
  output logic                    hazard_a,
  output logic                    hazard_b,
`ifdef WB_BYPASS_EN
  output logic [63:0]             bypass_data_a,
  output logic [63:0]             bypass_data_b,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [4:0]    XZR  = 5'd31;

  // Entry storage carries no reset: validity comes from head/count alone.
  logic [4:0]    addr_mem [DEPTH];
  logic [63:0]   data_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;

  logic accept;
  logic push;
  logic pop;

  assign in_ready = (count_q < FULL);
  assign accept   = in_valid && in_ready;
  // XZR writes complete the handshake but never occupy an entry.
  assign push     = accept && (in_address != XZR);
  // The register file never stalls, so a presented head always retires.
  assign write    = (count_q != '0);
  assign pop      = write;

  assign address  = write ? addr_mem[head] : 5'd0;
  assign data_in  = write ? data_mem[head] : 64'd0;
  assign count    = count_q;

  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[tail] <= in_address;
      data_mem[tail] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk entries from oldest (head) to youngest so the last match seen is the
  // youngest one; that is the value the register file will finally hold.
  logic [63:0] match_data_a;
  logic [63:0] match_data_b;

  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    hazard_a     = 1'b0;
    hazard_b     = 1'b0;
    match_data_a = 64'd0;
    match_data_b = 64'd0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count_q) begin
        if ((select_a != XZR) && (addr_mem[idx] == select_a)) begin
          hazard_a     = 1'b1;
          match_data_a = data_mem[idx];
        end
        if ((select_b != XZR) && (addr_mem[idx] == select_b)) begin
          hazard_b     = 1'b1;
          match_data_b = data_mem[idx];
        end
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign bypass_data_a = match_data_a;
  assign bypass_data_b = match_data_b;
`else
  // Match data only feeds the optional bypass outputs.
  logic unused_match;
  assign unused_match = ^{match_data_a, match_data_b};
`endif

endmodule
